// File: rtl/ram2_bus_ctrl_pkg.sv
// rtl/ram2_bus_ctrl_pkg.sv - shared RAM2 pin polarities, words and controller state encoding
package ram2_bus_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WR_SETUP = 2'd1,
    ST_WR_PULSE = 2'd2,
    ST_WR_HOLD  = 2'd3
  } ram2_state_e;

  localparam logic RamChipEnable    = 1'b0;
  localparam logic RamChipDisable   = 1'b1;
  localparam logic RamReadEnable    = 1'b0;
  localparam logic RamReadDisable   = 1'b1;
  localparam logic RamWriteEnable   = 1'b0;
  localparam logic RamWriteDisable  = 1'b1;

  localparam logic [15:0] NopInst  = 16'h0800;
  localparam logic [15:0] ZeroWord = 16'h0000;

  localparam int PulseCntW = 3;

endpackage

// File: rtl/ram2_wr_timer.sv
// rtl/ram2_wr_timer.sv - write-pulse width counter with load, decrement and last flag
module ram2_wr_timer
  import ram2_bus_ctrl_pkg::*;
#(
  parameter int LOAD_VAL = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  output logic last
);

  logic [PulseCntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = PulseCntW'(LOAD_VAL);
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last = (cnt_q == PulseCntW'(1));

endmodule

// File: rtl/ram2_bus_ctrl.sv
// rtl/ram2_bus_ctrl.sv - IF/MEM arbiter and timing controller for the single-port RAM2 SRAM
module ram2_bus_ctrl
  import ram2_bus_ctrl_pkg::*;
#(
  parameter int          ADDR_W       = 18,
  parameter logic [15:0] NOP_INST     = NopInst,
  parameter int          WR_PULSE_CYC = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       pc,
  input  logic              if_re,
  output logic [15:0]       inst,
  output logic              inst_valid,
  input  logic [15:0]       mem_addr_i,
  input  logic [15:0]       mem_data_i,
  input  logic              mem_re,
  input  logic              mem_we,
  output logic [15:0]       mem_data_o,
  output logic              mem_done,
  output logic              stall_req,
  output logic [ADDR_W-1:0] ram2_addr,
  output logic [15:0]       ram2_data_o,
  input  logic [15:0]       ram2_data_i,
  output logic              ram2_data_oe,
  output logic              ram2_en_n,
  output logic              ram2_oe_n,
  output logic              ram2_we_n
);

  ram2_state_e state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] inst_q, inst_d;
  logic        inst_valid_q, inst_valid_d;
  logic [15:0] mem_data_q, mem_data_d;
  logic        mem_done_q, mem_done_d;
  logic        wr_last;
  logic        wr_req, rd_req;

  // The cycle after mem_done the MEM request may still be high; it must not start a second access.
  assign wr_req = mem_we && !mem_done_q;
  assign rd_req = mem_re && !mem_we && !mem_done_q;

  ram2_wr_timer #(
    .LOAD_VAL(WR_PULSE_CYC)
  ) u_wr_timer (
    .clk (clk),
    .rst (rst),
    .load(state_q == ST_WR_SETUP),
    .dec (state_q == ST_WR_PULSE),
    .last(wr_last)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      addr_q       <= ZeroWord;
      wdata_q      <= ZeroWord;
      inst_q       <= NOP_INST;
      inst_valid_q <= 1'b0;
      mem_data_q   <= ZeroWord;
      mem_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      inst_q       <= inst_d;
      inst_valid_q <= inst_valid_d;
      mem_data_q   <= mem_data_d;
      mem_done_q   <= mem_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    inst_d       = inst_q;
    inst_valid_d = 1'b0;
    mem_data_d   = mem_data_q;
    mem_done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (wr_req) begin
          state_d = ST_WR_SETUP;
          addr_d  = mem_addr_i;
          wdata_d = mem_data_i;
          inst_d  = NOP_INST;
        end else if (rd_req) begin
          mem_data_d = ram2_data_i;
          mem_done_d = 1'b1;
          inst_d     = NOP_INST;
        end else if (if_re) begin
          inst_d       = ram2_data_i;
          inst_valid_d = 1'b1;
        end
      end
      ST_WR_SETUP: begin
        state_d = ST_WR_PULSE;
        inst_d  = NOP_INST;
      end
      ST_WR_PULSE: begin
        if (wr_last) state_d = ST_WR_HOLD;
        inst_d = NOP_INST;
      end
      default: begin
        state_d    = ST_IDLE;
        mem_done_d = 1'b1;
        inst_d     = NOP_INST;
      end
    endcase
  end

  always_comb begin
    ram2_addr    = '0;
    ram2_data_o  = ZeroWord;
    ram2_data_oe = 1'b0;
    ram2_en_n    = RamChipDisable;
    ram2_oe_n    = RamReadDisable;
    ram2_we_n    = RamWriteDisable;
    stall_req    = 1'b0;
    if (state_q == ST_IDLE) begin
      if (wr_req) begin
        stall_req = 1'b1;
      end else if (rd_req) begin
        ram2_addr = {{(ADDR_W-16){1'b0}}, mem_addr_i};
        ram2_en_n = RamChipEnable;
        ram2_oe_n = RamReadEnable;
        stall_req = 1'b1;
      end else if (if_re) begin
        ram2_addr = {{(ADDR_W-16){1'b0}}, pc};
        ram2_en_n = RamChipEnable;
        ram2_oe_n = RamReadEnable;
      end
    end else begin
      ram2_addr    = {{(ADDR_W-16){1'b0}}, addr_q};
      ram2_data_o  = wdata_q;
      ram2_data_oe = 1'b1;
      ram2_en_n    = RamChipEnable;
      ram2_we_n    = (state_q == ST_WR_PULSE) ? RamWriteEnable : RamWriteDisable;
      stall_req    = 1'b1;
    end
  end

  assign inst       = inst_q;
  assign inst_valid = inst_valid_q;
  assign mem_data_o = mem_data_q;
  assign mem_done   = mem_done_q;

endmodule

// File: tb/tb_ram2_bus_ctrl.sv
// tb/tb_ram2_bus_ctrl.sv - directed scoreboard bench for ram2_bus_ctrl with a behavioural SRAM
module tb_ram2_bus_ctrl;

  localparam int ADDR_W = 18;

  logic              clk = 1'b0;
  logic              rst;
  logic [15:0]       pc;
  logic              if_re;
  logic [15:0]       inst;
  logic              inst_valid;
  logic [15:0]       mem_addr_i;
  logic [15:0]       mem_data_i;
  logic              mem_re;
  logic              mem_we;
  logic [15:0]       mem_data_o;
  logic              mem_done;
  logic              stall_req;
  logic [ADDR_W-1:0] ram2_addr;
  logic [15:0]       ram2_data_o;
  logic [15:0]       ram2_data_i;
  logic              ram2_data_oe;
  logic              ram2_en_n;
  logic              ram2_oe_n;
  logic              ram2_we_n;

  always #5 clk = ~clk;

  ram2_bus_ctrl #(
    .ADDR_W      (ADDR_W),
    .NOP_INST    (16'h0800),
    .WR_PULSE_CYC(2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pc          (pc),
    .if_re       (if_re),
    .inst        (inst),
    .inst_valid  (inst_valid),
    .mem_addr_i  (mem_addr_i),
    .mem_data_i  (mem_data_i),
    .mem_re      (mem_re),
    .mem_we      (mem_we),
    .mem_data_o  (mem_data_o),
    .mem_done    (mem_done),
    .stall_req   (stall_req),
    .ram2_addr   (ram2_addr),
    .ram2_data_o (ram2_data_o),
    .ram2_data_i (ram2_data_i),
    .ram2_data_oe(ram2_data_oe),
    .ram2_en_n   (ram2_en_n),
    .ram2_oe_n   (ram2_oe_n),
    .ram2_we_n   (ram2_we_n)
  );

  // SRAM model: asynchronous read, write on the clock edge while we_n is low
  logic [15:0]       sram [0:(1<<ADDR_W)-1];
  logic              bk_we;
  logic [ADDR_W-1:0] bk_addr;
  logic [15:0]       bk_data;

  always @(posedge clk) begin
    if (bk_we) sram[bk_addr] <= bk_data;
    else if (!ram2_en_n && !ram2_we_n && ram2_data_oe) sram[ram2_addr] <= ram2_data_o;
  end

  assign ram2_data_i = (!ram2_en_n && !ram2_oe_n) ? sram[ram2_addr] : 16'h0000;

  int checks   = 0;
  int failures = 0;
  int viol     = 0;
  logic [15:0] exp_q[$];

  always @(negedge clk) begin
    if ((!ram2_we_n && !ram2_oe_n) || (ram2_data_oe && !ram2_oe_n)) viol++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sb_pop(input string tag, input logic [15:0] obs);
    logic [31:0] e;
    e = 32'hFFFF_FFFF;
    if (exp_q.size() != 0) e = {16'h0, exp_q.pop_front()};
    chk(tag, {16'h0, obs}, e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [ADDR_W-1:0] a, input logic [15:0] d);
    bk_addr = a;
    bk_data = d;
    bk_we   = 1'b1;
    step();
    bk_we   = 1'b0;
  endtask

  task automatic do_write(input logic [15:0] a, input logic [15:0] d, input logic with_re,
                          output int edges, output int we_low, output int oe_low, output int bad);
    edges = 0; we_low = 0; oe_low = 0; bad = 0;
    mem_addr_i = a;
    mem_data_i = d;
    mem_we     = 1'b1;
    mem_re     = with_re;
    if_re      = 1'b1;
    pc         = 16'h0001;
    #1;
    if (!ram2_oe_n) oe_low++;
    if (stall_req !== 1'b1) bad++;
    for (int c = 0; c < 20; c++) begin
      step();
      edges++;
      if (mem_done === 1'b1) break;
      if (!ram2_we_n) we_low++;
      if (!ram2_oe_n) oe_low++;
      if (ram2_data_oe !== 1'b1 || ram2_addr !== {2'b00, a} || ram2_data_o !== d ||
          stall_req !== 1'b1 || inst_valid !== 1'b0 || ram2_en_n !== 1'b0) bad++;
    end
    mem_we = 1'b0;
    mem_re = 1'b0;
    if_re  = 1'b0;
  endtask

  initial begin
    logic [15:0] prog [3];
    int edges, we_low, oe_low, bad, seen;
    prog[0] = 16'h0800;
    prog[1] = 16'h6AFF;
    prog[2] = 16'h6B55;

    rst = 1'b0; pc = '0; if_re = 1'b0; mem_addr_i = '0; mem_data_i = '0;
    mem_re = 1'b0; mem_we = 1'b0; bk_we = 1'b0; bk_addr = '0; bk_data = '0;
    preload(18'h00000, 16'h0800);
    preload(18'h00001, 16'h6AFF);
    preload(18'h00002, 16'h6B55);
    preload(18'h000C0, 16'hBEEF);
    preload(18'h0FFFF, 16'h1357);
    step();

    chk("rst_inst", inst, 16'h0800);
    chk("rst_valid", inst_valid, 1'b0);
    chk("rst_mdata", mem_data_o, 16'h0000);
    chk("rst_done", mem_done, 1'b0);
    chk("rst_en_n", ram2_en_n, 1'b1);
    chk("rst_oe_n", ram2_oe_n, 1'b1);
    chk("rst_we_n", ram2_we_n, 1'b1);
    chk("rst_data_oe", ram2_data_oe, 1'b0);
    chk("rst_addr", ram2_addr, 18'h0);
    rst = 1'b1;

    // fetch stream
    for (int i = 0; i < 3; i++) begin
      pc = 16'(i);
      if_re = 1'b1;
      #1;
      chk("f_stall", stall_req, 1'b0);
      chk("f_addr", ram2_addr, 32'(i));
      exp_q.push_back(prog[i]);
      step();
      sb_pop("f_inst", inst);
      chk("f_valid", inst_valid, 1'b1);
    end
    if_re = 1'b0;
    step();
    chk("idle_valid", inst_valid, 1'b0);
    chk("idle_hold", inst, 16'h6B55);

    // load with a competing fetch, request held one extra cycle
    mem_addr_i = 16'h00C0;
    mem_re = 1'b1;
    if_re = 1'b1;
    pc = 16'h0002;
    #1;
    chk("ld_stall", stall_req, 1'b1);
    chk("ld_addr", ram2_addr, 18'h000C0);
    chk("ld_oe_n", ram2_oe_n, 1'b0);
    exp_q.push_back(16'hBEEF);
    step();
    sb_pop("ld_data", mem_data_o);
    chk("ld_done", mem_done, 1'b1);
    chk("ld_inst_nop", inst, 16'h0800);
    chk("ld_valid", inst_valid, 1'b0);
    chk("ld_guard_stall", stall_req, 1'b0);
    exp_q.push_back(16'h6B55);
    step();
    chk("ld_done_pulse", mem_done, 1'b0);
    sb_pop("ld_guard_fetch", inst);
    chk("ld_guard_valid", inst_valid, 1'b1);
    mem_re = 1'b0;
    if_re = 1'b0;
    step();

    // store, pulse width 2
    do_write(16'h0010, 16'h1234, 1'b0, edges, we_low, oe_low, bad);
    chk("st_edges", edges, 5);
    chk("st_we_low", we_low, 2);
    chk("st_oe_low", oe_low, 0);
    chk("st_stable", bad, 0);
    chk("st_inst_nop", inst, 16'h0800);
    chk("st_sram", sram[18'h00010], 16'h1234);
    step();
    chk("st_done_pulse", mem_done, 1'b0);

    // load and store together: write wins
    do_write(16'h0020, 16'hA5A5, 1'b1, edges, we_low, oe_low, bad);
    chk("rw_edges", edges, 5);
    chk("rw_we_low", we_low, 2);
    chk("rw_no_read", oe_low, 0);
    chk("rw_stable", bad, 0);
    chk("rw_sram", sram[18'h00020], 16'hA5A5);
    chk("rw_mdata_keep", mem_data_o, 16'hBEEF);
    step();

    // reset in the middle of the write pulse
    mem_addr_i = 16'h0030;
    mem_data_i = 16'h5555;
    mem_we = 1'b1;
    step();
    step();
    chk("rw_pulse_we", ram2_we_n, 1'b0);
    chk("rw_pulse_oe", ram2_data_oe, 1'b1);
    rst = 1'b0;
    mem_we = 1'b0;
    step();
    chk("rmid_we_n", ram2_we_n, 1'b1);
    chk("rmid_data_oe", ram2_data_oe, 1'b0);
    chk("rmid_en_n", ram2_en_n, 1'b1);
    chk("rmid_stall", stall_req, 1'b0);
    chk("rmid_inst", inst, 16'h0800);
    rst = 1'b1;
    seen = 0;
    if (mem_done) seen++;
    repeat (5) begin
      step();
      if (mem_done) seen++;
    end
    chk("rmid_no_done", seen, 0);

    // top-of-range fetch address is zero-extended
    pc = 16'hFFFF;
    if_re = 1'b1;
    #1;
    chk("hi_addr", ram2_addr, 18'h0FFFF);
    exp_q.push_back(16'h1357);
    step();
    sb_pop("hi_inst", inst);
    chk("hi_valid", inst_valid, 1'b1);
    if_re = 1'b0;
    step();

    chk("pin_protocol", viol, 0);
    chk("sb_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
